// File: rtl/apb_sram_v2_if.sv
// APB4 bus bundle for apb_sram_v2.
//   paddr_i   : byte address (ADDR_WIDTH word-index bits + byte-offset bits)
//   psel_i    : slave select
//   penable_i : access phase
//   pwrite_i  : 1 = write
//   pstrb_i   : write byte strobes, one per byte lane
//   pwdata_i  : write data
//   pready_o  : transfer complete
//   prdata_o  : read data
//   pslverr_o : error response, valid only while pready_o = 1
// Modports: master drives the request side, slave drives the response side.
interface apb_sram_v2_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned BYTE_OFS   = $clog2(STRB_WIDTH);

   logic [ADDR_WIDTH+BYTE_OFS-1:0] paddr_i;
   logic                           psel_i;
   logic                           penable_i;
   logic                           pwrite_i;
   logic [STRB_WIDTH-1:0]          pstrb_i;
   logic [DATA_WIDTH-1:0]          pwdata_i;
   logic                           pready_o;
   logic [DATA_WIDTH-1:0]          prdata_o;
   logic                           pslverr_o;

   modport master (
      output paddr_i, psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i,
      input  pready_o, prdata_o, pslverr_o
   );

   modport slave (
      input  paddr_i, psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i,
      output pready_o, prdata_o, pslverr_o
   );
endinterface

// File: rtl/apb_sram_v2.sv
// APB4 slave with an integrated word-addressed SRAM array.
// Byte strobes scale with DATA_WIDTH, read latency (RD_LAT) and write wait
// states (WR_WAIT) are configurable, and misaligned, out-of-range or
// write-protected accesses complete with SLVERR without touching the array.
// Ports:
//   pclk_i   : APB clock
//   prst_n_i : asynchronous active-low reset
//   bus      : APB slave bundle (apb_sram_v2_if.slave)
module apb_sram_v2 #(
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned WR_WAIT    = 0,
   parameter int unsigned RO_EN      = 0,
   parameter int unsigned RO_BASE    = 0,
   parameter int unsigned RO_LIMIT   = 0
) (
   input logic         pclk_i,
   input logic         prst_n_i,
   apb_sram_v2_if.slave bus
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned BYTE_OFS   = $clog2(STRB_WIDTH);
   localparam logic [1:0]  RD_CNT0    = 2'(RD_LAT - 1);
   localparam logic [1:0]  WR_CNT0    = 2'(WR_WAIT);
   localparam logic [31:0] RO_SPAN    = 32'(RO_LIMIT - RO_BASE);

   typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_WR_WAIT, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           idx32;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  protect_hit;
   logic                  err;
   logic                  setup;
   logic                  rd_issue;
   logic                  mem_we;

   assign idx   = bus.paddr_i[BYTE_OFS +: ADDR_WIDTH];
   assign setup = bus.psel_i && !bus.penable_i && (state_q == ST_IDLE);

   if (BYTE_OFS > 0) begin : g_align
      assign misaligned = |bus.paddr_i[BYTE_OFS-1:0];
   end else begin : g_no_align
      assign misaligned = 1'b0;
   end

   // Range checks run on a 32-bit copy so they hold for any MEM_DEPTH;
   // the protected window uses one unsigned compare (idx - base <= span).
   always_comb begin
      idx32                   = '0;
      idx32[ADDR_WIDTH-1:0]   = idx;
      out_of_range            = (idx32 >= MEM_DEPTH);
      protect_hit             = (RO_EN != 0) && bus.pwrite_i &&
                                ((idx32 - RO_BASE) <= RO_SPAN);
      err                     = misaligned || out_of_range || protect_hit;
   end

   assign rd_issue = setup && !err && !bus.pwrite_i;

   // State register
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; dropping psel mid-transfer abandons it
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (setup) begin
               if (err)               state_d = ST_DONE;
               else if (bus.pwrite_i) state_d = ST_WR_WAIT;
               else                   state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (!bus.psel_i || cnt_q == 2'd0) state_d = ST_IDLE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs; the write commits only on the completing cycle
   always_comb begin
      bus.pready_o  = 1'b0;
      bus.pslverr_o = 1'b0;
      bus.prdata_o  = '0;
      mem_we        = 1'b0;
      unique case (state_q)
         ST_RD_WAIT: begin
            if (bus.psel_i && cnt_q == 2'd0) begin
               bus.pready_o = 1'b1;
               bus.prdata_o = rdata_q;
            end
         end
         ST_WR_WAIT: begin
            if (bus.psel_i && cnt_q == 2'd0) begin
               bus.pready_o = 1'b1;
               mem_we       = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.psel_i) begin
               bus.pready_o  = 1'b1;
               bus.pslverr_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Setup-phase capture and wait-state counter
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         strb_q  <= '0;
         wdata_q <= '0;
      end else if (setup) begin
         idx_q   <= idx;
         strb_q  <= bus.pstrb_i;
         wdata_q <= bus.pwdata_i;
         cnt_q   <= bus.pwrite_i ? WR_CNT0 : RD_CNT0;
      end else if ((state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) && cnt_q != 2'd0) begin
         cnt_q <= cnt_q - 2'd1;
      end
   end

   // Array: not reset. Read data is captured on the edge ending setup and
   // held in rdata_q for the remaining latency cycles.
   always_ff @(posedge pclk_i) begin
      if (rd_issue) rdata_q <= mem[idx];
      if (mem_we) begin
         for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            if (strb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_apb_sram_v2.sv
module tb_apb_sram_v2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] pwdata = '0;
   int unsigned dsel = 0;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   logic        rdy [4];
   logic        slverr [4];
   logic [31:0] rdat [4];

   always #5 clk = ~clk;

   apb_sram_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0 ();
   apb_sram_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus1 ();
   apb_sram_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus2 ();
   apb_sram_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus3 ();

   assign bus0.paddr_i = paddr[11:0];  assign bus0.psel_i = psel && (dsel == 0);
   assign bus0.penable_i = penable;    assign bus0.pwrite_i = pwrite;
   assign bus0.pstrb_i = pstrb;        assign bus0.pwdata_i = pwdata;
   assign bus1.paddr_i = paddr[12:0];  assign bus1.psel_i = psel && (dsel == 1);
   assign bus1.penable_i = penable;    assign bus1.pwrite_i = pwrite;
   assign bus1.pstrb_i = pstrb;        assign bus1.pwdata_i = pwdata;
   assign bus2.paddr_i = paddr[11:0];  assign bus2.psel_i = psel && (dsel == 2);
   assign bus2.penable_i = penable;    assign bus2.pwrite_i = pwrite;
   assign bus2.pstrb_i = pstrb;        assign bus2.pwdata_i = pwdata;
   assign bus3.paddr_i = paddr[11:0];  assign bus3.psel_i = psel && (dsel == 3);
   assign bus3.penable_i = penable;    assign bus3.pwrite_i = pwrite;
   assign bus3.pstrb_i = pstrb;        assign bus3.pwdata_i = pwdata;

   assign rdy[0] = bus0.pready_o;  assign slverr[0] = bus0.pslverr_o;  assign rdat[0] = bus0.prdata_o;
   assign rdy[1] = bus1.pready_o;  assign slverr[1] = bus1.pslverr_o;  assign rdat[1] = bus1.prdata_o;
   assign rdy[2] = bus2.pready_o;  assign slverr[2] = bus2.pslverr_o;  assign rdat[2] = bus2.prdata_o;
   assign rdy[3] = bus3.pready_o;  assign slverr[3] = bus3.pslverr_o;  assign rdat[3] = bus3.prdata_o;

   // defaults
   apb_sram_v2 #(.MEM_DEPTH(1024), .DATA_WIDTH(32), .ADDR_WIDTH(10)) u_dut0 (
      .pclk_i(clk), .prst_n_i(rst_n), .bus(bus0));
   // longer latency, one extra address bit so idx 1024 is reachable
   apb_sram_v2 #(.MEM_DEPTH(1024), .DATA_WIDTH(32), .ADDR_WIDTH(11), .RD_LAT(3), .WR_WAIT(2)) u_dut1 (
      .pclk_i(clk), .prst_n_i(rst_n), .bus(bus1));
   // write-protected window, non-power-of-2 depth
   apb_sram_v2 #(.MEM_DEPTH(1000), .DATA_WIDTH(32), .ADDR_WIDTH(10), .RO_EN(1), .RO_BASE(4), .RO_LIMIT(7)) u_dut2 (
      .pclk_i(clk), .prst_n_i(rst_n), .bus(bus2));
   apb_sram_v2 #(.MEM_DEPTH(1024), .DATA_WIDTH(32), .ADDR_WIDTH(10), .WR_WAIT(3)) u_dut3 (
      .pclk_i(clk), .prst_n_i(rst_n), .bus(bus3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after completion,
   // so consecutive calls are back-to-back.
   task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rd, output logic er,
                           output int waits);
      paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      while (!rdy[dsel] && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      check("pready", 32'(rdy[dsel]), 32'd1);
      rd = rdat[dsel];
      er = slverr[dsel];
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          w;

      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", 32'(rdy[0]), 32'd0);
      check("rst_pslverr", 32'(slverr[0]), 32'd0);
      check("rst_prdata", rdat[0], 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // defaults: write then immediate read-back
      dsel = 0;
      apb_xfer(1, 16'h010, 32'hDEADBEEF, 4'hF, rd, er, w);
      check("t1_wr_err", 32'(er), 0);  check("t1_wr_waits", 32'(w), 0);
      apb_xfer(0, 16'h010, 32'h0, 4'h0, rd, er, w);
      check("t1_rd_data", rd, 32'hDEADBEEF);
      check("t1_rd_err", 32'(er), 0);  check("t1_rd_waits", 32'(w), 0);

      // partial strobes, then an all-zero strobe write
      apb_xfer(1, 16'h020, 32'hFFFFFFFF, 4'hF, rd, er, w);
      apb_xfer(1, 16'h020, 32'h12345678, 4'b0101, rd, er, w);
      apb_xfer(0, 16'h020, 32'h0, 4'h0, rd, er, w);
      check("t2_rd_data", rd, 32'hFF34FF78);
      apb_xfer(1, 16'h020, 32'h00000000, 4'h0, rd, er, w);
      check("t2_zero_strb_err", 32'(er), 0);
      apb_xfer(0, 16'h020, 32'h0, 4'hF, rd, er, w);
      check("t2_zero_strb_data", rd, 32'hFF34FF78);

      // misaligned accesses
      apb_xfer(0, 16'h002, 32'h0, 4'h0, rd, er, w);
      check("t3_mis_err", 32'(er), 1);  check("t3_mis_data", rd, 0);  check("t3_mis_waits", 32'(w), 0);
      apb_xfer(1, 16'h012, 32'h00000000, 4'hF, rd, er, w);
      check("t3_mis_wr_err", 32'(er), 1);
      apb_xfer(0, 16'h010, 32'h0, 4'h0, rd, er, w);
      check("t3_mis_wr_nochg", rd, 32'hDEADBEEF);

      // out of range and latency on dut1
      dsel = 1;
      apb_xfer(0, 16'h1000, 32'h0, 4'h0, rd, er, w);
      check("t3_oor_err", 32'(er), 1);  check("t3_oor_data", rd, 0);  check("t3_oor_waits", 32'(w), 0);
      apb_xfer(1, 16'h040, 32'hCAFEF00D, 4'hF, rd, er, w);
      check("t4_wr_err", 32'(er), 0);  check("t4_wr_waits", 32'(w), 2);
      apb_xfer(0, 16'h040, 32'h0, 4'h0, rd, er, w);
      check("t4_rd_data", rd, 32'hCAFEF00D);  check("t4_rd_waits", 32'(w), 2);

      // psel dropped mid-read
      paddr = 16'h040; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      check("t6_drop_rd_busy", 32'(rdy[1]), 0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      check("t6_drop_rd_idle", 32'(rdy[1]), 0);
      // psel dropped mid-write: the write must be discarded
      paddr = 16'h040; pwrite = 1'b1; pwdata = 32'h0; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      apb_xfer(0, 16'h040, 32'h0, 4'h0, rd, er, w);
      check("t6_drop_wr_data", rd, 32'hCAFEF00D);  check("t6_drop_wr_waits", 32'(w), 2);

      // write-protected window idx 4..7, depth 1000
      dsel = 2;
      apb_xfer(1, 16'h014, 32'hA5A5A5A5, 4'hF, rd, er, w);
      check("t5_ro_err", 32'(er), 1);  check("t5_ro_waits", 32'(w), 0);
      apb_xfer(0, 16'h014, 32'h0, 4'h0, rd, er, w);
      check("t5_ro_rd_err", 32'(er), 0);
      check("t5_ro_nochg", 32'(rd == 32'hA5A5A5A5), 0);
      apb_xfer(1, 16'h010, 32'h44444444, 4'hF, rd, er, w);
      check("t5_ro_base_err", 32'(er), 1);
      apb_xfer(1, 16'h01C, 32'h77777777, 4'hF, rd, er, w);
      check("t5_ro_limit_err", 32'(er), 1);
      apb_xfer(1, 16'h00C, 32'h33333333, 4'hF, rd, er, w);
      check("t5_below_err", 32'(er), 0);
      apb_xfer(1, 16'h020, 32'h88888888, 4'hF, rd, er, w);
      check("t5_above_err", 32'(er), 0);
      apb_xfer(0, 16'h00C, 32'h0, 4'h0, rd, er, w);
      check("t5_below_data", rd, 32'h33333333);
      apb_xfer(0, 16'h020, 32'h0, 4'h0, rd, er, w);
      check("t5_above_data", rd, 32'h88888888);
      apb_xfer(1, 16'hF9C, 32'h99999999, 4'hF, rd, er, w);
      check("t5_last_wr_err", 32'(er), 0);
      apb_xfer(0, 16'hF9C, 32'h0, 4'h0, rd, er, w);
      check("t5_last_data", rd, 32'h99999999);
      apb_xfer(0, 16'hFA0, 32'h0, 4'h0, rd, er, w);
      check("t5_depth_err", 32'(er), 1);  check("t5_depth_data", rd, 0);

      // reset pulse during write wait states
      dsel = 3;
      apb_xfer(1, 16'h030, 32'h11111111, 4'hF, rd, er, w);
      check("t6_w3_waits", 32'(w), 3);
      paddr = 16'h030; pwrite = 1'b1; pwdata = 32'h22222222; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      check("t6_w3_busy", 32'(rdy[3]), 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_pready", 32'(rdy[3]), 0);
      check("t6_rst_pslverr", 32'(slverr[3]), 0);
      check("t6_rst_prdata", rdat[3], 0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      apb_xfer(0, 16'h030, 32'h0, 4'h0, rd, er, w);
      check("t6_rst_nochg", rd, 32'h11111111);
      check("t6_rst_rd_waits", 32'(w), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
